// File: rtl/arrow_plotter_pkg.sv
// Shared codes for the arrow plotter: direction encodings, FSM states and arrow segments.
package arrow_plotter_pkg;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_PACE = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEG_SHAFT = 2'd0,
    SEG_A     = 2'd1,
    SEG_B     = 2'd2
  } seg_e;
endpackage

// File: rtl/arrow_plotter_if.sv
// Game-FSM request side and VGA pixel side of the arrow plotter.
interface arrow_plotter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           start;
  logic [1:0]     dir;
  logic           erase;
  logic [2:0]     colour_in;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output start, dir, erase, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, dir, erase, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/arrow_plotter_pixel_pacer.sv
// Pixel pacing down-counter: while enabled, tick fires after TICKS_PER_PIXEL-1 cycles.
module arrow_plotter_pixel_pacer #(
  parameter int TICKS_PER_PIXEL = 3125000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  // the STEP cycle itself is one of the TICKS_PER_PIXEL cycles, hence the -2 reload
  localparam int RELOAD = (TICKS_PER_PIXEL > 2) ? TICKS_PER_PIXEL - 2 : 0;
  localparam int CNT_W  = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(RELOAD);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == '0);
endmodule

// File: rtl/arrow_plotter.sv
// Paced plotter for one arrow (shaft + two head arms) in one of four directions.
// state | meaning
// IDLE  | waiting for start; step 0 is computed from the live inputs
// STEP  | one pixel on the outputs (plot high if on screen)
// PACE  | waiting out the rest of the pixel period
// DONE  | one-cycle done pulse, then back to IDLE
module arrow_plotter
  import arrow_plotter_pkg::*;
#(
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int ORIGIN_X        = 79,
  parameter int ORIGIN_Y        = 63,
  parameter int ARM_LEN         = 8,
  parameter int HEAD_LEN        = 4,
  parameter int TICKS_PER_PIXEL = 3125000
) (
  input  logic            clk,
  input  logic            reset_n,
  arrow_plotter_if.slave  bus
);
  localparam bit PACED = (TICKS_PER_PIXEL > 1);
  localparam int K_MAX = (ARM_LEN > HEAD_LEN + 1) ? ARM_LEN : HEAD_LEN + 1;
  localparam int K_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  localparam logic [K_W-1:0]   K_ARM_LAST = K_W'(ARM_LEN - 1);
  localparam logic [K_W-1:0]   K_HEAD     = K_W'(HEAD_LEN);
  localparam logic [K_W-1:0]   K_ONE      = K_W'(1);
  localparam logic signed [X_W:0] OX = (X_W+1)'(ORIGIN_X);
  localparam logic signed [Y_W:0] OY = (Y_W+1)'(ORIGIN_Y);
  localparam logic signed [X_W:0] SW = (X_W+1)'(SCREEN_W);
  localparam logic signed [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

  state_e         state;
  seg_e           seg, seg_nxt;
  logic [K_W-1:0] k, k_nxt;
  dir_e           dir_q, dir_use;
  logic           last_q, last_step;
  logic           tick, emit, finish, on_screen;
  logic signed [X_W:0] px, kx, pkx;
  logic signed [Y_W:0] py, ky, pky;

  arrow_plotter_pixel_pacer #(.TICKS_PER_PIXEL(TICKS_PER_PIXEL)) u_pacer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state == S_PACE),
    .clear   (state != S_PACE),
    .tick    (tick)
  );

  // (seg, k) names the next pixel to emit; arm A offsets by +k*p, arm B by -k*p
  always_comb begin
    dir_use = (state == S_IDLE) ? dir_e'(bus.dir) : dir_q;
    kx  = (X_W+1)'(k);
    ky  = (Y_W+1)'(k);
    pkx = '0;
    pky = '0;
    if (seg == SEG_A) begin
      pkx = kx;
      pky = ky;
    end else if (seg == SEG_B) begin
      pkx = -kx;
      pky = -ky;
    end
    px = OX;
    py = OY;
    unique case (dir_use)
      DIR_RIGHT: begin px = OX - kx;  py = OY - pky; end
      DIR_LEFT:  begin px = OX + kx;  py = OY - pky; end
      DIR_UP:    begin px = OX - pkx; py = OY + ky;  end
      DIR_DOWN:  begin px = OX - pkx; py = OY - ky;  end
    endcase
    on_screen = !px[X_W] && (px < SW) && !py[Y_W] && (py < SH);

    seg_nxt   = seg;
    k_nxt     = k + K_ONE;
    last_step = 1'b0;
    case (seg)
      SEG_SHAFT: if (k == K_ARM_LAST) begin seg_nxt = SEG_A; k_nxt = K_ONE; end
      SEG_A:     if (k == K_HEAD)     begin seg_nxt = SEG_B; k_nxt = K_ONE; end
      default:   if (k == K_HEAD)     last_step = 1'b1;
    endcase

    emit   = ((state == S_IDLE) && bus.start)
          || ((state == S_STEP) && !PACED && !last_q)
          || ((state == S_PACE) && tick && !last_q);
    finish = ((state == S_STEP) && !PACED && last_q)
          || ((state == S_PACE) && tick && last_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      seg        <= SEG_SHAFT;
      k          <= '0;
      dir_q      <= DIR_RIGHT;
      last_q     <= 1'b0;
      bus.x      <= X_W'(ORIGIN_X);
      bus.y      <= Y_W'(ORIGIN_Y);
      bus.colour <= 3'b000;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.plot <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          dir_q      <= dir_e'(bus.dir);
          bus.colour <= bus.erase ? 3'b000 : bus.colour_in;
          bus.busy   <= 1'b1;
          state      <= S_STEP;
        end
        S_STEP: if (PACED) state <= S_PACE;
        S_PACE: if (tick) state <= S_STEP;
        S_DONE: state <= S_IDLE;
      endcase
      if (emit) begin
        bus.x    <= px[X_W-1:0];
        bus.y    <= py[Y_W-1:0];
        bus.plot <= on_screen;
        seg      <= seg_nxt;
        k        <= k_nxt;
        last_q   <= last_step;
      end
      if (finish) begin
        state    <= S_DONE;
        bus.done <= 1'b1;
        bus.busy <= 1'b0;
        seg      <= SEG_SHAFT;
        k        <= '0;
        last_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arrow_plotter.sv
// Directed bench for arrow_plotter: three instances (back-to-back, clipped origin, paced).
module tb_arrow_plotter;
  import arrow_plotter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int   sel = 0;
  logic start_drv = 1'b0;
  logic [1:0] dir_drv = 2'd0;
  logic erase_drv = 1'b0;
  logic [2:0] col_drv = 3'b000;

  arrow_plotter_if #(.X_W(8), .Y_W(7)) if1 ();
  arrow_plotter_if #(.X_W(8), .Y_W(7)) if2 ();
  arrow_plotter_if #(.X_W(8), .Y_W(7)) if4 ();

  assign if1.start = start_drv && (sel == 0);
  assign if2.start = start_drv && (sel == 1);
  assign if4.start = start_drv && (sel == 2);
  assign if1.dir = dir_drv;  assign if2.dir = dir_drv;  assign if4.dir = dir_drv;
  assign if1.erase = erase_drv; assign if2.erase = erase_drv; assign if4.erase = erase_drv;
  assign if1.colour_in = col_drv; assign if2.colour_in = col_drv; assign if4.colour_in = col_drv;

  arrow_plotter #(.TICKS_PER_PIXEL(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  arrow_plotter #(.ORIGIN_X(2), .TICKS_PER_PIXEL(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  arrow_plotter #(.TICKS_PER_PIXEL(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_col;
  logic o_plot, o_busy, o_done;

  always_comb begin
    o_x = if1.x; o_y = if1.y; o_col = if1.colour;
    o_plot = if1.plot; o_busy = if1.busy; o_done = if1.done;
    if (sel == 1) begin
      o_x = if2.x; o_y = if2.y; o_col = if2.colour;
      o_plot = if2.plot; o_busy = if2.busy; o_done = if2.done;
    end else if (sel == 2) begin
      o_x = if4.x; o_y = if4.y; o_col = if4.colour;
      o_plot = if4.plot; o_busy = if4.busy; o_done = if4.done;
    end
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cap_x[32], cap_y[32], cap_c[32], cap_cyc[32];
  int n_plot, done_at, busy_cnt;

  int ex2_x[16] = '{79,78,77,76,75,74,73,72, 78,77,76,75, 78,77,76,75};
  int ex2_y[16] = '{63,63,63,63,63,63,63,63, 62,61,60,59, 64,65,66,67};

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call at #1 after an edge with start_drv already high; c counts cycles from the accepting edge.
  task automatic capture(input int max_cyc, input int pulse_at, input bit hold, input int stop_plots);
    n_plot = 0; done_at = -1; busy_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      if (o_plot && n_plot < 32) begin
        cap_x[n_plot] = o_x; cap_y[n_plot] = o_y;
        cap_c[n_plot] = o_col; cap_cyc[n_plot] = c;
        n_plot++;
      end
      if (o_busy) busy_cnt++;
      if (c == 0 && !hold) start_drv = 1'b0;
      if (c == pulse_at) begin start_drv = 1'b1; dir_drv = 2'd3; end
      if (c == pulse_at + 1) start_drv = 1'b0;
      if (o_done) begin done_at = c; break; end
      if (stop_plots > 0 && n_plot == stop_plots) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    // 1: asynchronous reset, no clock edge yet
    #1 reset_n = 1'b0;
    #1;
    check("rst_x", if1.x, 79);
    check("rst_y", if1.y, 63);
    check("rst_plot", if1.plot, 0);
    check("rst_busy", if1.busy, 0);
    check("rst_done", if1.done, 0);
    check("rst_x_u2", if2.x, 2);
    #1 reset_n = 1'b1;
    idle(2);

    // 2: RIGHT, back-to-back
    sel = 0; dir_drv = 2'd0; col_drv = 3'b100; erase_drv = 1'b0; start_drv = 1'b1;
    capture(40, -10, 1'b0, 0);
    check("t2_nplot", n_plot, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_x%0d", i), cap_x[i], ex2_x[i]);
      check($sformatf("t2_y%0d", i), cap_y[i], ex2_y[i]);
      check($sformatf("t2_col%0d", i), cap_c[i], 4);
      check($sformatf("t2_cyc%0d", i), cap_cyc[i], i);
    end
    check("t2_done_at", done_at, 16);
    check("t2_busy_cnt", busy_cnt, 16);
    idle(1);
    check("t2_done_pulse", o_done, 0);

    // start held high across done: IDLE for one cycle, then a fresh draw
    start_drv = 1'b1;
    capture(40, -10, 1'b1, 0);
    check("hold_done_at", done_at, 16);
    idle(1);
    check("hold_idle_plot", o_plot, 0);
    check("hold_idle_busy", o_busy, 0);
    idle(1);
    check("hold_restart_plot", o_plot, 1);
    check("hold_restart_busy", o_busy, 1);
    start_drv = 1'b0;
    idle(20);

    // 3: UP
    dir_drv = 2'd2; start_drv = 1'b1;
    capture(40, -10, 1'b0, 0);
    check("t3_nplot", n_plot, 16);
    check("t3_p1_x", cap_x[0], 79);  check("t3_p1_y", cap_y[0], 63);
    check("t3_p8_x", cap_x[7], 79);  check("t3_p8_y", cap_y[7], 70);
    check("t3_p9_x", cap_x[8], 78);  check("t3_p9_y", cap_y[8], 64);
    check("t3_p13_x", cap_x[12], 80); check("t3_p13_y", cap_y[12], 64);
    check("t3_p16_x", cap_x[15], 83); check("t3_p16_y", cap_y[15], 67);
    idle(2);

    // 4: erase, LEFT; start pulse and dir change mid-draw are ignored
    dir_drv = 2'd1; erase_drv = 1'b1; col_drv = 3'b111; start_drv = 1'b1;
    capture(40, 5, 1'b0, 0);
    check("t4_nplot", n_plot, 16);
    for (int i = 0; i < 16; i++) check($sformatf("t4_col%0d", i), cap_c[i], 0);
    check("t4_p6_x", cap_x[5], 84);
    check("t4_p9_x", cap_x[8], 80);
    check("t4_p9_y", cap_y[8], 62);
    check("t4_done_at", done_at, 16);
    idle(3);
    check("t4_no_requeue_busy", o_busy, 0);
    check("t4_no_requeue_plot", o_plot, 0);
    erase_drv = 1'b0;

    // 5: ORIGIN_X=2, RIGHT, clipped at the left edge
    sel = 1; dir_drv = 2'd0; col_drv = 3'b010; start_drv = 1'b1;
    capture(40, -10, 1'b0, 0);
    check("t5_nplot", n_plot, 7);
    check("t5_p1_x", cap_x[0], 2);
    check("t5_p3_x", cap_x[2], 0);
    check("t5_p4_x", cap_x[3], 1);  check("t5_p4_y", cap_y[3], 62);
    check("t5_p4_cyc", cap_cyc[3], 8);
    check("t5_p7_x", cap_x[6], 0);  check("t5_p7_y", cap_y[6], 65);
    check("t5_p7_cyc", cap_cyc[6], 13);
    check("t5_done_at", done_at, 16);
    idle(2);

    // 6: TICKS=4 pacing, reset after plot 5
    sel = 2; dir_drv = 2'd0; col_drv = 3'b001; start_drv = 1'b1;
    capture(100, -10, 1'b0, 5);
    check("t6_nplot", n_plot, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t6_cyc%0d", i), cap_cyc[i], 4 * i);
    check("t6_p5_x", cap_x[4], 75);
    reset_n = 1'b0;
    #1;
    check("t6_rst_x", o_x, 79);
    check("t6_rst_y", o_y, 63);
    check("t6_rst_plot", o_plot, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_col", o_col, 0);
    idle(2);
    reset_n = 1'b1;
    begin
      int done_seen = 0;
      int busy_seen = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (o_done) done_seen++;
        if (o_busy) busy_seen++;
      end
      check("t6_no_done", done_seen, 0);
      check("t6_no_busy", busy_seen, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
